regfile_mp: RTL

- Parametrised multi-read-port integer register file for the RISC-V datapath core.
- Generalised in XLEN, register count and read-port count.
- Adds a hard-wired zero register, write-to-read bypass and asynchronous clear.
- Adds a per-register pending-write scoreboard that lets the decode stage stall on operands whose producer, e.g. a load, has not yet written back.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_scoreboard.sv | 56 +++++
 rtl/regfile_mp.sv | 86 ++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port integer register file.
// Provides the default XLEN/NREGS configuration, an address-width helper
// and the register-address type for the default configuration.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 64;
  localparam int unsigned NREGS_DEF = 32;

  // Address width needed to index n registers.
  function automatic int unsigned addr_w(input int unsigned n);
    return $clog2(n);
  endfunction

  localparam int unsigned AW_DEF = addr_w(NREGS_DEF);

  typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   busy_set, busy_addr   mark a register as waiting for its producer
//   we, waddr             writeback clears the mark of the written register
//   flush                 drop every pending mark
//   busy_vec              registered busy bits, one per register
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned AW      = addr_w(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             busy_set,
  input  logic [AW-1:0]    busy_addr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic             flush,
  output logic [NREGS-1:0] busy_vec
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Per-bit priority: flush, then a new producer, then writeback, else hold.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned r = 0; r < NREGS; r++) begin
      if (flush) begin
        busy_d[r] = 1'b0;
      end else if (busy_set && (busy_addr == AW'(r))) begin
        busy_d[r] = 1'b1;
      end else if (we && (waddr == AW'(r))) begin
        busy_d[r] = 1'b0;
      end
    end
    // x0 never has a producer to wait for.
    if (ZERO_REG) begin
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with optional hard-wired x0,
// same-cycle write-to-read bypass and a pending-write scoreboard.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   we, waddr, wdata      write port (commits on the rising edge)
//   raddr                 packed read addresses, port i at [i*AW +: AW]
//   rdata                 combinational read data, port i at [i*XLEN +: XLEN]
//   rbusy                 per-port operand-pending flag (combinational)
//   busy_set, busy_addr   mark a register as pending a write
//   flush                 clear all pending marks
//   busy_vec              raw scoreboard state
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned NRD      = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW      = addr_w(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                busy_set,
  input  logic [AW-1:0]       busy_addr,
  input  logic                flush,
  output logic [NREGS-1:0]    busy_vec
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic            wr_en;

  // Writes to x0 are dropped when it is hard-wired.
  assign wr_en = we & ~(ZERO_REG & (waddr == '0));

  // Register storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
    end else if (wr_en) begin
      regs_q[waddr] <= wdata;
    end
  end

  // Pending-write scoreboard.
  regfile_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .busy_set  (busy_set),
    .busy_addr (busy_addr),
    .we        (we),
    .waddr     (waddr),
    .flush     (flush),
    .busy_vec  (busy_vec)
  );

  // Independent read ports: x0 first, then bypass, then storage.
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit;
    logic          is_zero;

    assign ra      = raddr[p*AW +: AW];
    assign hit     = we & (waddr == ra);
    assign is_zero = ZERO_REG & (ra == '0);

    assign rdata[p*XLEN +: XLEN] = is_zero          ? '0    :
                                   (BYPASS && hit)  ? wdata :
                                                      regs_q[ra];

    // A same-cycle writeback releases the stall only when it is forwarded.
    assign rbusy[p] = ~is_zero & busy_vec[ra] & ~(BYPASS & hit);
  end

endmodule
